fft_out_reorder: RTL
====================

FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 SHALL have parameter N, default 8, meaning FFT points per frame (power of 2, at least 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning bits per real/imaginary component.
REQ-003 SHALL have derived localparam LOG2N = log2(N), default 3.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_flag  input  1  input sample valid; no backpressure toward the FFT.
REQ-007 SHALL have port in_data  input  2*DATA_WIDTH  complex sample; re in [2*DW-1:DW], im in [DW-1:0]; arrives in bit-reversed order.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid sample.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the sample.
REQ-010 SHALL have port out_data  output  2*DATA_WIDTH  sample in natural order, same packing as in_data.
REQ-011 SHALL have port out_index  output  LOG2N  natural-order bin index of out_data.
REQ-012 SHALL have port out_last  output  1  high with bin N-1.
REQ-013 SHALL have port overflow  output  1  sticky; at least one input sample was dropped.

Function
REQ-014 SHALL hold two N-entry banks (ping-pong) with per-bank full flags.
REQ-015 SHALL count only cycles with in_flag=1 using a write counter k (0..N-1); gaps in in_flag are allowed and do not advance k.
REQ-016 SHALL write sample k to address bitrev(k) of the current write bank.
REQ-017 SHALL, on the capture edge of k=N-1, set that bank's full flag, toggle the write bank, and wrap k to 0.
REQ-018 SHALL drop any in_flag sample that arrives while the current write bank is full, leaving k unchanged and setting overflow to 1.
REQ-019 SHALL implement the read FSM with two states:
- IDLE -> STREAM when the read bank is full.
- STREAM -> IDLE after bin N-1 is accepted, unless the other bank is already full; in that case it stays in STREAM on the other bank with no bubble.
REQ-020 SHALL present bins in read address order 0..N-1, with out_index equal to the address.
REQ-021 SHALL use a registered output stage: a new sample loads when out_valid=0 or (out_valid and out_ready).
REQ-022 SHALL hold out_data, out_index and out_last stable while out_valid=1 and out_ready=0.
REQ-023 SHALL first assert out_valid at the second rising edge after the edge that captures the last sample of a frame.
REQ-024 SHALL clear a bank's full flag on the edge that accepts its bin N-1.
REQ-025 SHALL make a freed bank writable from the next cycle only; a sample arriving on the freeing edge, while the write bank is full, is dropped.
REQ-026 SHALL sustain 1 sample/cycle throughput when out_ready=1 continuously.
REQ-027 SHALL perform no arithmetic; data passes through bit-exact.

Reset
REQ-028 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_index=0, out_last=0, overflow=0, k=0, both full flags=0, write bank=0, read bank=0 and FSM=IDLE.
REQ-029 SHALL, on reset mid-frame, discard all buffered and partial data, with no output until a complete new frame arrives after rst_n rises.
REQ-030 SHALL NOT reset bank memory contents.

Verification
REQ-031 SHALL verify basic reorder: 8 contiguous samples d0..d7 (dk = {k+1, 8'h80+k}), out_ready=1 -> out sequence d0,d4,d2,d6,d1,d5,d3,d7 with index 0..7, out_last only on d7, first out_valid 2 edges after the d7 capture edge.
REQ-032 SHALL verify gapped input: in_flag toggling 1/0 over 16 cycles -> same output as REQ-031, with overflow=0.
REQ-033 SHALL verify backpressure: out_ready=0 for 5 cycles mid-frame -> out_data held constant, no sample lost or duplicated.
REQ-034 SHALL verify overflow: out_ready=0 throughout, 24 contiguous samples -> first 16 buffered, last 8 dropped, overflow=1; after out_ready=1 exactly 16 samples (frames 1, 2) are output back-to-back.
REQ-035 SHALL verify back-to-back frames: 32 contiguous samples, out_ready=1 -> 32 outputs, no bubble between frames, overflow=0.
REQ-036 SHALL verify reset mid-operation: rst_n pulsed low after sample 4 of a frame, then one full frame applied -> outputs all zero during reset, then exactly 8 outputs from the new frame only.

Source files
------------

// File: rtl/fft_out_reorder_if.sv
// Bus between the FFT core / downstream consumer and the output reorder buffer.
// master: the environment (FFT source + downstream sink); slave: the reorder block.
interface fft_out_reorder_if #(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 8
);
   localparam int LOG2N = $clog2(N);

   logic                    in_flag;
   logic [2*DATA_WIDTH-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [2*DATA_WIDTH-1:0] out_data;
   logic [LOG2N-1:0]        out_index;
   logic                    out_last;
   logic                    overflow;

   modport master (
      output in_flag, in_data, out_ready,
      input  out_valid, out_data, out_index, out_last, overflow
   );

   modport slave (
      input  in_flag, in_data, out_ready,
      output out_valid, out_data, out_index, out_last, overflow
   );
endinterface

// File: rtl/fft_out_reorder.sv
// FFT output reorder: bit-reversed input samples are written into a ping-pong
// buffer at bitrev(k) and streamed out in natural order through a registered
// valid/ready output stage. Samples arriving while the write bank is full are
// dropped and flagged by a sticky overflow bit.
module fft_out_reorder #(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   fft_out_reorder_if.slave   bus
);
   localparam int LOG2N = $clog2(N);
   localparam int DW2   = 2 * DATA_WIDTH;

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_STREAM = 1'b1;

   function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
      return r;
   endfunction

   // Bank memory: address {bank, bin}; never reset.
   logic [DW2-1:0]   r_mem [0:2*N-1];

   logic [LOG2N-1:0] r_wr_cnt;
   logic             r_wr_bank;
   logic [1:0]       r_full;
   logic             r_overflow;

   logic [0:0]       r_state;
   logic             r_rd_bank;
   logic [LOG2N-1:0] r_rd_addr;

   logic             r_out_valid;
   logic [DW2-1:0]   r_out_data;
   logic [LOG2N-1:0] r_out_index;
   logic             r_out_last;

   logic w_wr_en, w_drop, w_wr_wrap;
   logic w_acc, w_last_acc, w_load, w_rd_wrap;
   logic w_out_bank;

   assign w_wr_en    = bus.in_flag && !r_full[r_wr_bank];
   assign w_drop     = bus.in_flag &&  r_full[r_wr_bank];
   assign w_wr_wrap  = w_wr_en && (r_wr_cnt == LOG2N'(N-1));

   assign w_acc      = r_out_valid && bus.out_ready;
   assign w_last_acc = w_acc && r_out_last;
   // Once bin N-1 is loaded the read pointer has already moved to the other
   // bank, so the bank still being drained is the opposite one.
   assign w_out_bank = ~r_rd_bank;
   // Load the output stage whenever it is empty or being emptied this edge.
   // Requiring the read bank full lets the next frame follow bin N-1 with no
   // bubble when it is already buffered.
   assign w_load     = (r_state == S_STREAM) && r_full[r_rd_bank] &&
                       (!r_out_valid || bus.out_ready);
   assign w_rd_wrap  = w_load && (r_rd_addr == LOG2N'(N-1));

   // Sample capture into the write bank at the bit-reversed address.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[{r_wr_bank, f_bitrev(r_wr_cnt)}] <= bus.in_data;
   end

   // Write counter, write bank select and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_cnt   <= '0;
         r_wr_bank  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_cnt <= w_wr_wrap ? '0 : r_wr_cnt + LOG2N'(1);
            if (w_wr_wrap) r_wr_bank <= ~r_wr_bank;
         end
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   // Bank full flags: set on last capture, cleared when bin N-1 is accepted.
   // The two never hit the same bank on one edge (writes need an empty bank).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 2'b00;
      end else begin
         if (w_wr_wrap)  r_full[r_wr_bank]  <= 1'b1;
         if (w_last_acc) r_full[w_out_bank] <= 1'b0;
      end
   end

   // Read FSM: start streaming when the read bank fills; go idle after the
   // last bin is accepted unless the next bank is already waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   if (r_full[r_rd_bank]) r_state <= S_STREAM;
            S_STREAM: if (w_last_acc && !r_full[r_rd_bank]) r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   // Read address walks 0..N-1 and flips bank after loading bin N-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_addr <= '0;
         r_rd_bank <= 1'b0;
      end else if (w_load) begin
         r_rd_addr <= w_rd_wrap ? '0 : r_rd_addr + LOG2N'(1);
         if (w_rd_wrap) r_rd_bank <= ~r_rd_bank;
      end
   end

   // Registered output stage; contents hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_index <= '0;
         r_out_last  <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= r_mem[{r_rd_bank, r_rd_addr}];
         r_out_index <= r_rd_addr;
         r_out_last  <= (r_rd_addr == LOG2N'(N-1));
      end else if (w_acc) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_index = r_out_index;
   assign bus.out_last  = r_out_last;
   assign bus.overflow  = r_overflow;

endmodule
